// File: rtl/hbus_xfer_stm_if.sv
// Command, write/read stream and HyperBus PHY-side signals of the transaction engine.
// slave: the engine itself; master: the arbiter/PHY side that talks to it.
interface hbus_xfer_stm_if #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 5
);
    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic              req_reg;
    logic [31:0]       req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              done;
    logic              err;
    logic              csn;
    logic              oe;
    logic              oe_clk;
    logic [DATA_W-1:0] dq_out;
    logic [DATA_W-1:0] dq_in;
    logic              rwds_in;
    logic              rwds_out;
    logic              rwds_oe;

    modport slave (
        input  req_valid, req_rw, req_reg, req_addr, req_len, wr_data, wr_valid, dq_in, rwds_in,
        output req_ready, wr_ready, rd_data, rd_valid, done, err,
               csn, oe, oe_clk, dq_out, rwds_out, rwds_oe
    );

    modport master (
        output req_valid, req_rw, req_reg, req_addr, req_len, wr_data, wr_valid, dq_in, rwds_in,
        input  req_ready, wr_ready, rd_data, rd_valid, done, err,
               csn, oe, oe_clk, dq_out, rwds_out, rwds_oe
    );
endinterface

// File: rtl/hbus_xfer_stm.sv
// HyperBus transaction engine: memory/register read/write with CA build, 1x/2x latency,
// variable-length burst, completion and read-timeout reporting.
module hbus_xfer_stm #(
    parameter int DATA_W     = 16,
    parameter int BURST_MAX  = 16,
    parameter int LAT_CYC    = 6,
    parameter int RD_TIMEOUT = 64,
    parameter int LEN_W      = $clog2(BURST_MAX + 1)
) (
    input  logic            clk,
    input  logic            rst,
    hbus_xfer_stm_if.slave  bus
);
    localparam int MAX_A   = (2 * LAT_CYC > BURST_MAX) ? 2 * LAT_CYC : BURST_MAX;
    localparam int CNT_MAX = (MAX_A > RD_TIMEOUT) ? MAX_A : RD_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_CA, S_LAT, S_WDATA, S_RDATA, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;
    logic              lat2x_q, lat2x_d;
    logic              rw_q, rw_d;
    logic              reg_q, reg_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [31:0]       ca_lo_q, ca_lo_d;
    logic              req_ready_q, req_ready_d;
    logic              csn_q, csn_d;
    logic              oe_q, oe_d;
    logic              oe_clk_q, oe_clk_d;
    logic [DATA_W-1:0] dq_q, dq_d;
    logic              rwds_oe_q, rwds_oe_d;
    logic              wr_ready_q, wr_ready_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [47:0]       ca_new;
    logic              len_bad;
    logic [CNT_W-1:0]  lat_last;
    logic [CNT_W-1:0]  len_last;

    assign ca_new   = {bus.req_rw, bus.req_reg, 1'b1, bus.req_addr[31:3], 13'd0, bus.req_addr[2:0]};
    assign len_bad  = (bus.req_len == '0) || (bus.req_len > LEN_W'(BURST_MAX));
    // LAT counts the remainder of the latency after the three CA cycles.
    assign lat_last = lat2x_q ? CNT_W'(2 * LAT_CYC - 4) : CNT_W'(LAT_CYC - 4);
    assign len_last = CNT_W'(len_q) - CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        lat2x_d     = lat2x_q;
        rw_d        = rw_q;
        reg_d       = reg_q;
        len_d       = len_q;
        ca_lo_d     = ca_lo_q;
        req_ready_d = req_ready_q;
        csn_d       = csn_q;
        oe_d        = 1'b0;
        oe_clk_d    = oe_clk_q;
        dq_d        = '0;
        rwds_oe_d   = 1'b0;
        wr_ready_d  = 1'b0;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    rw_d        = bus.req_rw;
                    reg_d       = bus.req_reg;
                    len_d       = (bus.req_reg && !bus.req_rw) ? LEN_W'(1) : bus.req_len;
                    ca_lo_d     = ca_new[31:0];
                    req_ready_d = 1'b0;
                    cnt_d       = '0;
                    if (len_bad) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = S_CA;
                        csn_d    = 1'b0;
                        oe_clk_d = 1'b1;
                        oe_d     = 1'b1;
                        dq_d     = DATA_W'(ca_new[47:32]);
                    end
                end
            end
            S_CA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == '0) begin
                    lat2x_d = bus.rwds_in;
                end
                if (cnt_q == CNT_W'(2)) begin
                    cnt_d = '0;
                    // Register writes carry their single data word with zero latency.
                    if (reg_q && !rw_q) begin
                        state_d    = S_WDATA;
                        oe_d       = 1'b1;
                        wr_ready_d = 1'b1;
                    end else begin
                        state_d = S_LAT;
                    end
                end else begin
                    oe_d = 1'b1;
                    dq_d = (cnt_q == '0) ? DATA_W'(ca_lo_q[31:16]) : DATA_W'(ca_lo_q[15:0]);
                end
            end
            S_LAT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == lat_last) begin
                    cnt_d = '0;
                    tmo_d = '0;
                    if (rw_q) begin
                        state_d = S_RDATA;
                    end else begin
                        state_d    = S_WDATA;
                        oe_d       = 1'b1;
                        wr_ready_d = 1'b1;
                        rwds_oe_d  = !reg_q;
                    end
                end
            end
            S_WDATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == len_last) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    oe_d       = 1'b1;
                    wr_ready_d = 1'b1;
                    rwds_oe_d  = !reg_q;
                end
            end
            S_RDATA: begin
                tmo_d = tmo_q + CNT_W'(1);
                if (bus.rwds_in) begin
                    rd_data_d  = bus.dq_in;
                    rd_valid_d = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                end
                if (bus.rwds_in && (cnt_q == len_last)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (tmo_q == CNT_W'(RD_TIMEOUT - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            S_DONE: begin
                // csn and CK enable are released leaving DONE, giving CS hold after the last word.
                state_d     = S_IDLE;
                csn_d       = 1'b1;
                oe_clk_d    = 1'b0;
                req_ready_d = 1'b1;
                cnt_d       = '0;
                tmo_d       = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            lat2x_q     <= 1'b0;
            rw_q        <= 1'b0;
            reg_q       <= 1'b0;
            len_q       <= '0;
            ca_lo_q     <= '0;
            req_ready_q <= 1'b1;
            csn_q       <= 1'b1;
            oe_q        <= 1'b0;
            oe_clk_q    <= 1'b0;
            dq_q        <= '0;
            rwds_oe_q   <= 1'b0;
            wr_ready_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            lat2x_q     <= lat2x_d;
            rw_q        <= rw_d;
            reg_q       <= reg_d;
            len_q       <= len_d;
            ca_lo_q     <= ca_lo_d;
            req_ready_q <= req_ready_d;
            csn_q       <= csn_d;
            oe_q        <= oe_d;
            oe_clk_q    <= oe_clk_d;
            dq_q        <= dq_d;
            rwds_oe_q   <= rwds_oe_d;
            wr_ready_q  <= wr_ready_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Write words stream straight through in the cycle they are offered; a missing word is masked.
    assign bus.dq_out    = (state_q == S_WDATA) ? (bus.wr_valid ? bus.wr_data : '0) : dq_q;
    assign bus.rwds_out  = (state_q == S_WDATA) && !bus.wr_valid;
    assign bus.req_ready = req_ready_q;
    assign bus.csn       = csn_q;
    assign bus.oe        = oe_q;
    assign bus.oe_clk    = oe_clk_q;
    assign bus.rwds_oe   = rwds_oe_q;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_hbus_xfer_stm.sv
// Bench for hbus_xfer_stm: a per-cycle timeline model built from phase lengths, checked every cycle,
// plus directed scenarios whose key values are pinned to hand-computed literals.
module tb_hbus_xfer_stm;
    localparam int DATA_W     = 16;
    localparam int BURST_MAX  = 16;
    localparam int LAT_CYC    = 6;
    localparam int RD_TIMEOUT = 64;
    localparam int LEN_W      = 5;

    typedef struct packed {
        logic        csn, oe, oe_clk, rwds_out, rwds_oe, wr_ready, rd_valid, done, err, req_ready;
        logic [15:0] dq_out, rd_data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hbus_xfer_stm_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    hbus_xfer_stm #(
        .DATA_W(DATA_W), .BURST_MAX(BURST_MAX), .LAT_CYC(LAT_CYC),
        .RD_TIMEOUT(RD_TIMEOUT), .LEN_W(LEN_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_c;
    bit   exp_on   = 0;
    int   cyc      = -1;

    // What the DUT showed during the current transaction, for the literal pins.
    int          csn_low, done_at, done_err;
    logic [15:0] ca_seen [3];
    logic [15:0] rd_seen [$];
    logic [15:0] wd_seen [$];
    logic        rwm_seen[$];

    logic [15:0] wd_arr [16];
    logic        wv_arr [16];
    logic [15:0] rdq_arr[16];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, a, e);
    endtask

    always @(negedge clk) begin
        if (exp_on) begin
            chk("csn",       32'(bus.csn),       32'(exp_c.csn));
            chk("oe",        32'(bus.oe),        32'(exp_c.oe));
            chk("oe_clk",    32'(bus.oe_clk),    32'(exp_c.oe_clk));
            chk("dq_out",    32'(bus.dq_out),    32'(exp_c.dq_out));
            chk("rwds_out",  32'(bus.rwds_out),  32'(exp_c.rwds_out));
            chk("rwds_oe",   32'(bus.rwds_oe),   32'(exp_c.rwds_oe));
            chk("wr_ready",  32'(bus.wr_ready),  32'(exp_c.wr_ready));
            chk("rd_valid",  32'(bus.rd_valid),  32'(exp_c.rd_valid));
            chk("done",      32'(bus.done),      32'(exp_c.done));
            chk("err",       32'(bus.err),       32'(exp_c.err));
            chk("req_ready", 32'(bus.req_ready), 32'(exp_c.req_ready));
            if (exp_c.rd_valid) chk("rd_data", 32'(bus.rd_data), 32'(exp_c.rd_data));
            if (!bus.csn) csn_low++;
            if (bus.done) begin
                done_at  = cyc;
                done_err = int'(bus.err);
            end
            if (bus.rd_valid) rd_seen.push_back(bus.rd_data);
            if (cyc >= 1 && cyc <= 3) ca_seen[cyc-1] = bus.dq_out;
            if (bus.wr_ready) begin
                wd_seen.push_back(bus.dq_out);
                rwm_seen.push_back(bus.rwds_out);
            end
        end
    end

    task automatic clear_rec();
        csn_low  = 0;
        done_at  = -99;
        done_err = -1;
        rd_seen.delete();
        wd_seen.delete();
        rwm_seen.delete();
        for (int i = 0; i < 3; i++) ca_seen[i] = 16'hxxxx;
    endtask

    task automatic scramble_inputs();
        bus.req_rw   = 1'($urandom_range(0, 1));
        bus.req_reg  = 1'($urandom_range(0, 1));
        bus.req_addr = $urandom;
        bus.req_len  = LEN_W'($urandom_range(0, 31));
        bus.wr_data  = 16'($urandom);
        bus.wr_valid = 1'($urandom_range(0, 1));
        bus.dq_in    = 16'($urandom);
        bus.rwds_in  = 1'($urandom_range(0, 1));
    endtask

    task automatic idle_cycle();
        exp_t e;
        rst           = 1'b0;
        scramble_inputs();
        bus.req_valid = 1'b0;
        e             = '0;
        e.csn         = 1'b1;
        e.req_ready   = 1'b1;
        exp_c         = e;
        cyc           = -1;
        exp_on        = 1;
        @(posedge clk); #1;
    endtask

    task automatic run_txn(input bit rw, input bit rg, input logic [31:0] addr, input int len,
                           input bit l2x, input int rd_pct, input int abort_at);
        exp_t        e;
        bit          bad, regw, rd_end, rerr, prev_rv, nxt_rv, r;
        int          eff_len, n_lat, ds, dn, cap, idx;
        logic [15:0] prev_rd, nxt_rd;
        logic [47:0] ca;
        bad     = (len == 0) || (len > BURST_MAX);
        regw    = rg && !rw;
        eff_len = regw ? 1 : len;
        n_lat   = regw ? 0 : ((l2x ? 2 * LAT_CYC : LAT_CYC) - 3);
        ds      = 4 + n_lat;
        ca      = {rw, rg, 1'b1, addr[31:3], 13'd0, addr[2:0]};
        dn      = bad ? 1 : (rw ? -1 : ds + eff_len);
        cap     = 0;
        rd_end  = 0;
        rerr    = 0;
        prev_rv = 0;
        prev_rd = '0;
        clear_rec();
        for (int c = 0; c < 300; c++) begin
            rst = (abort_at > 0 && c == abort_at);
            scramble_inputs();
            bus.req_valid = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (c == 0) begin
                bus.req_rw   = rw;
                bus.req_reg  = rg;
                bus.req_addr = addr;
                bus.req_len  = LEN_W'(len);
            end
            if (c == 1) bus.rwds_in = l2x;
            e           = '0;
            e.csn       = 1'b1;
            e.req_ready = (c == 0);
            e.rd_valid  = prev_rv;
            e.rd_data   = prev_rd;
            nxt_rv      = 0;
            nxt_rd      = '0;
            if (!bad && c >= 1 && (dn < 0 || c <= dn)) begin
                e.csn    = 1'b0;
                e.oe_clk = 1'b1;
            end
            if (!bad && c >= 1 && c <= 3) begin
                e.oe     = 1'b1;
                e.dq_out = (c == 1) ? ca[47:32] : ((c == 2) ? ca[31:16] : ca[15:0]);
            end
            if (!bad && !rw && c >= ds && c < ds + eff_len) begin
                idx          = c - ds;
                bus.wr_valid = wv_arr[idx];
                bus.wr_data  = wd_arr[idx];
                e.oe         = 1'b1;
                e.wr_ready   = 1'b1;
                e.dq_out     = wv_arr[idx] ? wd_arr[idx] : 16'h0000;
                e.rwds_out   = !wv_arr[idx];
                e.rwds_oe    = !rg;
            end
            if (!bad && rw && c >= ds && !rd_end) begin
                r           = ($urandom_range(0, 99) < rd_pct);
                bus.rwds_in = r;
                if (r) begin
                    bus.dq_in = rdq_arr[cap];
                    nxt_rv    = 1;
                    nxt_rd    = rdq_arr[cap];
                    cap++;
                end
                if (cap == eff_len) begin
                    dn     = c + 1;
                    rd_end = 1;
                end else if (c - ds == RD_TIMEOUT - 1) begin
                    dn     = c + 1;
                    rd_end = 1;
                    rerr   = 1;
                end
            end
            if (c == dn) begin
                e.done = 1'b1;
                e.err  = bad | rerr;
            end
            prev_rv = nxt_rv;
            prev_rd = nxt_rd;
            exp_c   = e;
            cyc     = c;
            exp_on  = 1;
            @(posedge clk); #1;
            if (c == dn || (abort_at > 0 && c == abort_at)) break;
        end
        rst = 1'b0;
        $display("txn rw=%0d reg=%0d addr=%h len=%0d lat2x=%0d abort=%0d done_at=%0d err=%0d rd_words=%0d",
                 rw, rg, addr, len, l2x, abort_at, done_at, done_err, rd_seen.size());
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) begin
            wd_arr[i]  = 16'($urandom);
            wv_arr[i]  = ($urandom_range(0, 3) != 0);
            rdq_arr[i] = 16'($urandom);
        end
    endtask

    initial begin
        bit          rw, rg, l2x;
        int          len, pct;
        logic [31:0] addr;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        scramble_inputs();
        repeat (3) @(posedge clk);
        #1;
        // Reset state, observed while reset is still held.
        exp_c     = '0;
        exp_c.csn = 1'b1;
        exp_c.req_ready = 1'b1;
        exp_on    = 1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycle();

        // Memory write, 1x latency.
        fill_random();
        for (int i = 0; i < 16; i++) wv_arr[i] = 1'b1;
        run_txn(0, 0, 32'h0000_0012, 4, 0, 100, 0);
        chk("pin_ca0", 32'(ca_seen[0]), 32'h2000);
        chk("pin_ca1", 32'(ca_seen[1]), 32'h0002);
        chk("pin_ca2", 32'(ca_seen[2]), 32'h0002);
        chk("pin_csn_low", 32'(csn_low), 32'd11);
        chk("pin_wr_done_at", 32'(done_at), 32'd11);
        chk("pin_wr_words", 32'(wd_seen.size()), 32'd4);
        idle_cycle();

        // Memory read, 2x latency.
        fill_random();
        rdq_arr[0] = 16'hA5A5;
        rdq_arr[1] = 16'h5A5A;
        run_txn(1, 0, 32'h0040_1234, 2, 1, 100, 0);
        chk("pin_rd_done_at", 32'(done_at), 32'd15);
        chk("pin_rd_err", 32'(done_err), 32'd0);
        chk("pin_rd_cnt", 32'(rd_seen.size()), 32'd2);
        chk("pin_rd0", 32'(rd_seen.size() > 0 ? rd_seen[0] : 16'hxxxx), 32'hA5A5);
        chk("pin_rd1", 32'(rd_seen.size() > 1 ? rd_seen[1] : 16'hxxxx), 32'h5A5A);

        // Register write: zero latency, length forced to one.
        fill_random();
        wv_arr[0] = 1'b1;
        wd_arr[0] = 16'h8F1F;
        run_txn(0, 1, 32'h0000_0000, 3, 1, 100, 0);
        chk("pin_reg_ca0", 32'(ca_seen[0]), 32'h6000);
        chk("pin_reg_done_at", 32'(done_at), 32'd5);
        chk("pin_reg_words", 32'(wd_seen.size()), 32'd1);
        chk("pin_reg_dq", 32'(wd_seen.size() > 0 ? wd_seen[0] : 16'hxxxx), 32'h8F1F);
        idle_cycle();

        // Masked middle word.
        fill_random();
        wv_arr[0] = 1'b1; wv_arr[1] = 1'b0; wv_arr[2] = 1'b1;
        run_txn(0, 0, 32'h0000_0100, 3, 0, 100, 0);
        chk("pin_mask0", 32'(rwm_seen.size() > 0 ? rwm_seen[0] : 1'bx), 32'd0);
        chk("pin_mask1", 32'(rwm_seen.size() > 1 ? rwm_seen[1] : 1'bx), 32'd1);
        chk("pin_mask2", 32'(rwm_seen.size() > 2 ? rwm_seen[2] : 1'bx), 32'd0);
        chk("pin_mask_dq", 32'(wd_seen.size() > 1 ? wd_seen[1] : 16'hxxxx), 32'h0000);

        // Read timeout with no strobes at all.
        fill_random();
        run_txn(1, 0, 32'h0000_0200, 4, 0, 0, 0);
        chk("pin_tmo_done_at", 32'(done_at), 32'd71);
        chk("pin_tmo_err", 32'(done_err), 32'd1);
        chk("pin_tmo_rd", 32'(rd_seen.size()), 32'd0);
        idle_cycle();

        // Zero length.
        run_txn(0, 0, 32'h0000_0300, 0, 0, 100, 0);
        chk("pin_len0_done_at", 32'(done_at), 32'd1);
        chk("pin_len0_err", 32'(done_err), 32'd1);
        chk("pin_len0_csn", 32'(csn_low), 32'd0);

        // Reset in the middle of WDATA (cycles 7..14 for len 8 at 1x).
        fill_random();
        run_txn(0, 0, 32'h0000_0400, 8, 0, 100, 9);
        idle_cycle();
        chk("pin_abort_no_done", 32'(done_at), 32'hFFFF_FF9D);

        for (int t = 0; t < 40; t++) begin
            rw   = 1'($urandom_range(0, 1));
            rg   = ($urandom_range(0, 3) == 0);
            addr = $urandom;
            len  = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 17)
                                                : int'($urandom_range(1, 16));
            l2x  = 1'($urandom_range(0, 1));
            pct  = ($urandom_range(0, 9) == 0) ? 10 : int'($urandom_range(50, 100));
            fill_random();
            run_txn(rw, rg, addr, len, l2x, pct, 0);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        exp_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
